// File: rtl/seg_mux_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: N hex digits share one segment bus, with
// per-digit blank/blink/dp, leading-zero suppression, dead time and tear-free frame loading.
module seg_mux_scan_driver #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned CLK_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES   = 2,
  parameter int unsigned BLINK_FRAMES  = 25,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  lz_suppress,
  input  logic                  load,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DivW-1:0]     DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]     DeadLen = DivW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0]     IdxLast = IdxW'(N_DIGITS - 1);
  localparam logic [FrmW-1:0]     FrmLast = FrmW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] AnOff   = {N_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink;
    logic [N_DIGITS-1:0]   dpm;
    logic                  lz;
  } disp_t;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            blink_q, blink_d;
  logic            slot_end, frame_end;
  disp_t           pend_q, act_q, pend_in;

  assign slot_end  = enable && (div_q == DivLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  assign pend_in = '{digits: digits_in, blank: blank_mask, blink: blink_mask,
                     dpm: dp_mask, lz: lz_suppress};

  always_comb begin
    div_d   = div_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    if (enable) begin
      div_d = slot_end ? '0 : div_q + 1'b1;
    end
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frm_q == FrmLast) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  logic [N_DIGITS-1:0] lz_dark;
  logic                zeros_above, this_zero;

  always_comb begin
    lz_dark     = '0;
    zeros_above = 1'b1;
    this_zero   = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      this_zero   = (act_q.digits[4*i +: 4] == 4'h0);
      lz_dark[i]  = act_q.lz && this_zero && zeros_above;
      zeros_above = zeros_above && this_zero;
    end
  end

  logic [3:0]          cur_hex;
  logic                cur_dark, cur_dp;
  logic [N_DIGITS-1:0] an_on;

  always_comb begin
    cur_hex  = '0;
    cur_dark = 1'b0;
    cur_dp   = 1'b0;
    an_on    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_hex  = act_q.digits[4*i +: 4];
        cur_dark = act_q.blank[i] | (act_q.blink[i] & blink_q) | lz_dark[i];
        cur_dp   = act_q.dpm[i];
        an_on[i] = 1'b1;
      end
    end
  end

  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                tick_q;

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = AnOff;
    if (enable) begin
      if (!cur_dark) begin
        seg_d = hex7(cur_hex);
        dp_d  = ~cur_dp;
      end
      // Dead time at slot start keeps the previous digit from ghosting onto this one.
      if (div_q >= DeadLen) begin
        an_d = AN_ACTIVE_LOW ? ~an_on : an_on;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      pend_q  <= '0;
      act_q   <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= AnOff;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      if (load) begin
        pend_q <= pend_in;
      end
      // Active copy only changes at a frame boundary so a frame never mixes old and new data.
      if (frame_end) begin
        act_q <= pend_q;
      end
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_scan_driver.sv
// Scoreboard bench for seg_mux_scan_driver: expected slot outputs are queued as stimulus is
// planned; a monitor pops one entry per cycle in which any anode is driven.
module tb_seg_mux_scan_driver;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int DEAD = 1;
  localparam int BF   = 2;
  localparam int FRM  = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask, blink_mask, dp_mask;
  logic        lz_suppress, load, enable;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  seg_mux_scan_driver #(
    .N_DIGITS     (N),
    .CLK_DIV      (DIV),
    .DEAD_CYCLES  (DEAD),
    .BLINK_FRAMES (BF),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .lz_suppress(lz_suppress),
    .load       (load),
    .enable     (enable),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dp} for digit slot i.
  function automatic logic [11:0] slot_exp(input logic [15:0] d, input logic [3:0] bl,
                                           input logic [3:0] bk, input logic [3:0] dm,
                                           input logic lz, input logic ph, input int i);
    logic [3:0]  h;
    logic        dark, upper_zero;
    logic [11:0] r;
    h = d[4*i +: 4];
    upper_zero = 1'b1;
    for (int j = i + 1; j < N; j++) if (d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    dark = bl[i] || (bk[i] && ph) || (lz && i != 0 && h == 4'h0 && upper_zero);
    r[11:8] = ~(4'b0001 << i);
    r[7:1]  = dark ? 7'h7F : seg_of(h);
    r[0]    = dark ? 1'b1 : ~dm[i];
    return r;
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                            input logic [3:0] dm, input logic lz, input logic ph);
    for (int i = 0; i < N; i++) repeat (DIV - DEAD) exp_q.push_back(slot_exp(d, bl, bk, dm, lz, ph, i));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_tick) ticks++;
      if (an !== 4'hF) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: got %0h, expected no anode active", {an, seg, dp});
        end else begin
          check("slot", {20'h0, an, seg, dp}, {20'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic start(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                       input logic [3:0] dm, input logic lz);
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    digits_in = d; blank_mask = bl; blink_mask = bk; dp_mask = dm; lz_suppress = lz;
    load = 1'b1;
    @(posedge clk);
    #1;
    load   = 1'b0;
    ticks  = 0;
    enable = 1'b1;
  endtask

  // Runs 'edges' enabled clock edges; loads land on enabled edge numbers la/lb.
  task automatic run(input int edges, input int la, input logic [15:0] va, input int lb,
                     input logic [15:0] vb, input int pause_at);
    int c;
    bit paused;
    c = 0;
    paused = 1'b0;
    while (c < edges) begin
      if (!paused && c == pause_at) begin
        paused = 1'b1;
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          check("paused_dark", {20'h0, an, seg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        end
        enable = 1'b1;
      end
      load = (c + 1 == la) || (c + 1 == lb);
      if (c + 1 == la) digits_in = va;
      if (c + 1 == lb) digits_in = vb;
      @(posedge clk);
      #1;
      c++;
    end
    load   = 1'b0;
    enable = 1'b0;
  endtask

  task automatic drain(input string name, input int frames);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_ticks"}, ticks, frames);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    digits_in = '0; blank_mask = '0; blink_mask = '0; dp_mask = '0;
    lz_suppress = 1'b0; load = 1'b0; enable = 1'b0;

    // Reset asserted mid-scan; the first frame still shows the all-zero reset contents.
    start(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (3) exp_q.push_back(slot_exp(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0));
    exp_q.push_back(slot_exp(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1));
    repeat (7) @(posedge clk);
    #1;
    check("pre_reset_drain", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_an", an, 4'hF);
    check("reset_tick", frame_tick, 1'b0);
    exp_q.delete();

    // Scan 0x1234, pause mid-slot, load 0xABCD mid-frame and 0x5678 on a frame boundary.
    start(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int f = 0; f < 7; f++) begin
      d = (f == 0) ? 16'h0 : (f < 3) ? 16'h1234 : (f < 6) ? 16'hABCD : 16'h5678;
      push_frame(d, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    run(7 * FRM, 2 * FRM + 6, 16'hABCD, 5 * FRM, 16'h5678, FRM + 2);
    drain("scan", 7);

    // Leading-zero suppression: 0x0050, then 0x0000.
    start(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
    push_frame(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    push_frame(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    run(4 * FRM, FRM + 4, 16'h0000, 0, 16'h0, -1);
    drain("lz", 4);

    // Blink on digit 0 (off in frames 2-3, 6-7) with dp on digit 2.
    start(16'h1234, 4'h0, 4'h1, 4'h4, 1'b0);
    for (int f = 0; f < 9; f++) begin
      if (f == 0) push_frame(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      else push_frame(16'h1234, 4'h0, 4'h1, 4'h4, 1'b0, ((f / BF) % 2) == 1);
    end
    run(9 * FRM, 0, 16'h0, 0, 16'h0, -1);
    drain("blink", 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
